// File: rtl/izh_pkg.sv
// ============================================================================
// Module : izh_pkg
// Brief  : Shared types, per-mode Izhikevich parameter table and saturation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package izh_pkg;

    localparam int PW = 64;
    typedef logic signed [PW-1:0] wide_t;

    typedef enum logic [2:0] {
        MODE_RS  = 3'd0,
        MODE_IB  = 3'd1,
        MODE_CH  = 3'd2,
        MODE_FS  = 3'd3,
        MODE_TC  = 3'd4,
        MODE_RZ  = 3'd5,
        MODE_LTS = 3'd6
    } izh_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        wide_t a;
        wide_t b;
        wide_t c;
        wide_t d;
        wide_t u_init;
    } izh_params_t;

    // All fixed-point constants below are scaled by 2^9 (F = 9).
    localparam wide_t VPEAK = 64'sd15360;
    localparam wide_t K004  = 64'sd20;
    localparam wide_t K140  = 64'sd71680;

    function automatic izh_params_t mk(input int a, input int b, input int c,
                                       input int d, input int u_init);
        izh_params_t p;
        p.a      = wide_t'(a);
        p.b      = wide_t'(b);
        p.c      = wide_t'(c);
        p.d      = wide_t'(d);
        p.u_init = wide_t'(u_init);
        return p;
    endfunction

    // Entry 7 duplicates RS so an illegal code behaves as mode 0.
    localparam izh_params_t MODE_TABLE [8] = '{
        mk(10, 102, -33280, 4096, -6656),   // RS
        mk(10, 102, -28160, 2048, -5632),   // IB
        mk(10, 102, -25600, 1024, -5120),   // CH
        mk(51, 102, -33280, 1024, -6656),   // FS
        mk(10, 128, -33280,   26, -8320),   // TC
        mk(51, 133, -33280, 1024, -8653),   // RZ
        mk(10, 128, -33280, 1024, -8320),   // LTS
        mk(10, 102, -33280, 4096, -6656)    // code 7 -> RS
    };

    function automatic wide_t sat(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi)
            return hi;
        if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/izh_update.sv
// ============================================================================
// Module : izh_update
// Brief  : Combinational one-neuron Izhikevich step with saturating results.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module izh_update
    import izh_pkg::*;
#(
    parameter int W        = 18,
    parameter int F        = 9,
    parameter int DT_SHIFT = 4
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] u,
    input  logic signed [W-1:0] cur,
    input  logic        [2:0]   mode,
    output logic signed [W-1:0] v_next,
    output logic signed [W-1:0] u_next,
    output logic                spike
);

    wide_t vw, uw, iw, sq, t, bv, du;

    always_comb begin
        vw = wide_t'(v);
        uw = wide_t'(u);
        iw = wide_t'(cur);
        sq = (vw * vw) >>> F;
        t  = ((sq * K004) >>> F) + wide_t'(5) * vw + K140 - uw + iw;
        bv = (MODE_TABLE[mode].b * vw) >>> F;
        du = ((MODE_TABLE[mode].a * (bv - uw)) >>> F) >>> DT_SHIFT;
        spike = (vw >= VPEAK);
        if (spike) begin
            v_next = W'(MODE_TABLE[mode].c);
            u_next = W'(sat(uw + MODE_TABLE[mode].d, W));
        end else begin
            v_next = W'(sat(vw + (t >>> DT_SHIFT), W));
            u_next = W'(sat(uw + du, W));
        end
    end

endmodule

`default_nettype wire

// File: rtl/izh_neuron_array.sv
// ============================================================================
// Module : izh_neuron_array
// Brief  : Time-multiplexed array of Izhikevich neurons, one update per clock.
//          Optional macro IZH_SPIKE_FIFO_EN adds a 4-deep spike FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module izh_neuron_array
    import izh_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int W         = 18,
    parameter int F         = 9,
    parameter int DT_SHIFT  = 4,
    parameter int AW        = $clog2(N_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                overrun_o,
    input  logic                cur_we,
    input  logic [AW-1:0]       cur_addr,
    input  logic signed [W-1:0] cur_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [2:0]          cfg_mode,
    output logic                spk_valid,
    input  logic                spk_ready,
    output logic [AW-1:0]       spk_id,
    input  logic [AW-1:0]       mon_addr,
    output logic signed [W-1:0] mon_v
);

    seq_state_e          state;
    logic [AW-1:0]       idx;
    logic signed [W-1:0] v_mem    [N_NEURONS];
    logic signed [W-1:0] u_mem    [N_NEURONS];
    logic signed [W-1:0] i_mem    [N_NEURONS];
    logic [2:0]          mode_mem [N_NEURONS];

    logic signed [W-1:0] v_upd, u_upd;
    logic                spike;
    logic                spk_push;
    logic                fifo_drop;
    logic                cfg_fire;
    logic [2:0]          cfg_mode_eff;

    assign cfg_ready    = !busy_o;
    assign cfg_fire     = cfg_valid && cfg_ready;
    assign cfg_mode_eff = (cfg_mode == 3'd7) ? 3'd0 : cfg_mode;
    assign spk_push     = (state == S_RUN) && spike;

    izh_update #(
        .W        (W),
        .F        (F),
        .DT_SHIFT (DT_SHIFT)
    ) u_update (
        .v      (v_mem[idx]),
        .u      (u_mem[idx]),
        .cur    (i_mem[idx]),
        .mode   (mode_mem[idx]),
        .v_next (v_upd),
        .u_next (u_upd),
        .spike  (spike)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
            mon_v     <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem[n]    <= W'(MODE_TABLE[MODE_RS].c);
                u_mem[n]    <= W'(MODE_TABLE[MODE_RS].u_init);
                i_mem[n]    <= '0;
                mode_mem[n] <= 3'd0;
            end
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step_i) begin
                        state  <= S_RUN;
                        busy_o <= 1'b1;
                        idx    <= '0;
                    end
                end
                S_RUN: begin
                    v_mem[idx] <= v_upd;
                    u_mem[idx] <= u_upd;
                    if (idx == AW'(N_NEURONS - 1)) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if ((state != S_IDLE && step_i) || fifo_drop)
                overrun_o <= 1'b1;

            // The datapath above already sampled the old current this cycle.
            if (cur_we)
                i_mem[cur_addr] <= cur_data;

            // cfg is only accepted outside RUN, so it never races a write-back.
            if (cfg_fire) begin
                mode_mem[cfg_addr] <= cfg_mode_eff;
                v_mem[cfg_addr]    <= W'(MODE_TABLE[cfg_mode_eff].c);
                u_mem[cfg_addr]    <= W'(MODE_TABLE[cfg_mode_eff].u_init);
            end

            mon_v <= v_mem[mon_addr];
        end
    end

`ifdef IZH_SPIKE_FIFO_EN
    logic [AW-1:0] fifo [4];
    logic [1:0]    rd_ptr, wr_ptr;
    logic [2:0]    count;
    logic          fifo_full, push_ok, pop;

    assign fifo_full = (count == 3'd4);
    assign push_ok   = spk_push && !fifo_full;
    assign pop       = (count != 3'd0) && spk_ready;
    assign fifo_drop = spk_push && fifo_full;
    assign spk_valid = (count != 3'd0);
    assign spk_id    = fifo[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < 4; k++)
                fifo[k] <= '0;
        end else begin
            if (push_ok) begin
                fifo[wr_ptr] <= idx;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push_ok} - {2'b00, pop};
        end
    end
`else
    logic unused_spk_ready;
    assign unused_spk_ready = spk_ready;
    assign fifo_drop        = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spk_valid <= 1'b0;
            spk_id    <= '0;
        end else begin
            spk_valid <= spk_push;
            if (spk_push)
                spk_id <= idx;
        end
    end
`endif

endmodule

`default_nettype wire
